// File: rtl/cr_isf_mc_pkg.sv
// Shared types and helpers for the multi-channel input stream FIFO.
// Holds the default-width beat payload, the arbiter state encoding and a
// popcount helper used for egress byte accounting.
package cr_isf_mc_pkg;

  localparam int unsigned ISF_DW   = 64;
  localparam int unsigned ISF_UW   = 8;
  localparam int unsigned POP_MAXW = 128;

  typedef struct packed {
    logic [ISF_DW-1:0]   tdata;
    logic [ISF_UW-1:0]   tuser;
    logic [ISF_DW/8-1:0] tstrb;
    logic                tlast;
  } isf_mc_beat_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Number of set bits; narrower vectors are zero-extended by the caller.
  function automatic int unsigned popcount(input logic [POP_MAXW-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(POP_MAXW); i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/cr_isf_mc_fifo.sv
// Per-channel synchronous FIFO of stream beats with occupancy output.
// Ports: clk/rst (sync, active-high); en gates readiness; in_valid/in_ready/
// in_beat ingress (in_ready registered); pop removes head_c (combinational
// head view); level is the registered occupancy 0..DEPTH.
module cr_isf_mc_fifo
  import cr_isf_mc_pkg::*;
#(
  parameter type         beat_t = isf_mc_beat_t,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  beat_t                  in_beat,
  input  logic                   pop,
  output beat_t                  head_c,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  beat_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          do_pop;
  logic [LW-1:0] level_nxt;

  // Push/pop qualification; full never pushes, empty never pops.
  always_comb begin
    push      = in_valid & in_ready & (level < LW'(DEPTH));
    do_pop    = pop & (level != '0);
    level_nxt = level + LW'(push) - LW'(do_pop);
  end

  assign head_c = mem[rd_ptr];

  // Pointers, occupancy and look-ahead ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      level    <= level_nxt;
      in_ready <= en & (level_nxt < LW'(DEPTH));
    end
  end

  // Storage, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_beat;
  end

endmodule

// File: rtl/cr_isf_mc.sv
// Multi-channel input stream FIFO: N_CH AXI4-stream ingress channels, each
// buffered in a DEPTH-entry FIFO, merged by a packet-granular round-robin
// arbiter onto one registered egress tagged with ob_tid.
// Ports: clk, rst (sync, active-high); ib_* per-channel ingress; ob_* egress;
// cfg_ch_en channel enables; cfg_single_step/ss_rd single-step gating;
// cfg_stall_limit/stall_int egress stall watchdog; ob_bytes_stb/amt per-beat
// byte count; fifo_level per-channel occupancy.
// Optional: define CR_ISF_MC_TRIG_EN to add the data-match trigger
// (cfg_trig_arm/match/mask, trig_hit, trig_cap_data, trig_cap_ch).
module cr_isf_mc
  import cr_isf_mc_pkg::*;
#(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned DW      = ISF_DW,
  parameter int unsigned UW      = ISF_UW,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned STALL_W = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_CH-1:0]                        ib_tvalid,
  output logic [N_CH-1:0]                        ib_tready,
  input  logic [N_CH*DW-1:0]                     ib_tdata,
  input  logic [N_CH*UW-1:0]                     ib_tuser,
  input  logic [N_CH*DW/8-1:0]                   ib_tstrb,
  input  logic [N_CH-1:0]                        ib_tlast,
  output logic                                   ob_tvalid,
  input  logic                                   ob_tready,
  output logic [DW-1:0]                          ob_tdata,
  output logic [UW-1:0]                          ob_tuser,
  output logic [DW/8-1:0]                        ob_tstrb,
  output logic                                   ob_tlast,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ob_tid,
  input  logic [N_CH-1:0]                        cfg_ch_en,
  input  logic                                   cfg_single_step,
  input  logic                                   ss_rd,
  input  logic [STALL_W-1:0]                     cfg_stall_limit,
  output logic                                   stall_int,
  output logic                                   ob_bytes_stb,
  output logic [$clog2(DW/8):0]                  ob_bytes_amt,
`ifdef CR_ISF_MC_TRIG_EN
  input  logic                                   cfg_trig_arm,
  input  logic [DW-1:0]                          cfg_trig_match,
  input  logic [DW-1:0]                          cfg_trig_mask,
  output logic                                   trig_hit,
  output logic [DW-1:0]                          trig_cap_data,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] trig_cap_ch,
`endif
  output logic [N_CH*($clog2(DEPTH)+1)-1:0]      fifo_level
);

  localparam int unsigned TW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned BW = $clog2(SW) + 1;

  typedef struct packed {
    logic [DW-1:0] tdata;
    logic [UW-1:0] tuser;
    logic [SW-1:0] tstrb;
    logic          tlast;
  } beat_t;

  beat_t              in_beat [N_CH];
  beat_t              head    [N_CH];
  logic [LW-1:0]      lvl     [N_CH];
  logic [N_CH-1:0]    nonempty;
  logic [N_CH-1:0]    pop;

  arb_state_e         state;
  logic [TW-1:0]      lock_ch;
  logic [TW-1:0]      ptr;
  logic [TW-1:0]      sel;
  logic [TW-1:0]      idx;
  logic               sel_ok;
  beat_t              hsel;

  logic               ss_credit;
  logic               ss_mode;
  logic               gate_open;
  logic               load;
  logic               xfer;
  logic [STALL_W-1:0] stall_cnt;
  logic [STALL_W-1:0] stall_nxt;

  // Per-channel buffering.
  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    assign in_beat[g] = {ib_tdata[g*DW +: DW], ib_tuser[g*UW +: UW],
                         ib_tstrb[g*SW +: SW], ib_tlast[g]};
    assign nonempty[g] = (lvl[g] != '0);
    assign pop[g]      = load & (sel == TW'(g));
    assign fifo_level[g*LW +: LW] = lvl[g];

    cr_isf_mc_fifo #(
      .beat_t (beat_t),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .en       (cfg_ch_en[g]),
      .in_valid (ib_tvalid[g]),
      .in_ready (ib_tready[g]),
      .in_beat  (in_beat[g]),
      .pop      (pop[g]),
      .head_c   (head[g]),
      .level    (lvl[g])
    );
  end

  // Grant selection: locked channel keeps priority regardless of its enable;
  // otherwise the first non-empty enabled channel at or after ptr wins
  // (descending scan so the nearest candidate is assigned last).
  always_comb begin
    sel    = lock_ch;
    sel_ok = 1'b0;
    idx    = '0;
    if (state == ARB_LOCKED) begin
      sel_ok = nonempty[lock_ch];
    end else begin
      for (int k = int'(N_CH) - 1; k >= 0; k--) begin
        idx = TW'((int'(ptr) + k) % int'(N_CH));
        if (nonempty[idx] && cfg_ch_en[idx]) begin
          sel    = idx;
          sel_ok = 1'b1;
        end
      end
    end
  end

  assign hsel = head[sel];

`ifdef CR_ISF_MC_TRIG_EN
  assign ss_mode = cfg_single_step | trig_hit;
`else
  assign ss_mode = cfg_single_step;
`endif

  assign gate_open = ~ss_mode | ss_credit;
  assign load      = (~ob_tvalid | ob_tready) & sel_ok & gate_open;
  assign xfer      = ob_tvalid & ob_tready;

  // Stall counter: cleared on transfer, saturates while held.
  always_comb begin
    stall_nxt = stall_cnt;
    if (xfer) stall_nxt = '0;
    else if (ob_tvalid && (stall_cnt != '1)) stall_nxt = stall_cnt + STALL_W'(1);
  end

  // Arbiter FSM, egress register, single-step credit, watchdog, byte strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB_IDLE;
      lock_ch      <= '0;
      ptr          <= '0;
      ss_credit    <= 1'b0;
      stall_cnt    <= '0;
      stall_int    <= 1'b0;
      ob_tvalid    <= 1'b0;
      ob_tdata     <= '0;
      ob_tuser     <= '0;
      ob_tstrb     <= '0;
      ob_tlast     <= 1'b0;
      ob_tid       <= '0;
      ob_bytes_stb <= 1'b0;
      ob_bytes_amt <= '0;
    end else begin
      // A pulse arriving with a load wins, so credit survives that cycle.
      if (ss_rd)     ss_credit <= 1'b1;
      else if (load) ss_credit <= 1'b0;

      if (load) begin
        ob_tvalid <= 1'b1;
        ob_tdata  <= hsel.tdata;
        ob_tuser  <= hsel.tuser;
        ob_tstrb  <= hsel.tstrb;
        ob_tlast  <= hsel.tlast;
        ob_tid    <= sel;
        if (hsel.tlast) begin
          state <= ARB_IDLE;
          ptr   <= (sel == TW'(N_CH - 1)) ? '0 : sel + TW'(1);
        end else begin
          state   <= ARB_LOCKED;
          lock_ch <= sel;
        end
      end else if (ob_tready) begin
        ob_tvalid <= 1'b0;
      end

      stall_cnt <= stall_nxt;
      stall_int <= (cfg_stall_limit != '0) && (stall_nxt == cfg_stall_limit) &&
                   (stall_cnt != cfg_stall_limit);

      ob_bytes_stb <= xfer;
      ob_bytes_amt <= xfer ? BW'(popcount(POP_MAXW'(ob_tstrb))) : '0;
    end
  end

`ifdef CR_ISF_MC_TRIG_EN
  // Data-match trigger: first hit while armed captures the loaded beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_hit      <= 1'b0;
      trig_cap_data <= '0;
      trig_cap_ch   <= '0;
    end else if (!cfg_trig_arm) begin
      trig_hit <= 1'b0;
    end else if (load && !trig_hit &&
                 (((hsel.tdata ^ cfg_trig_match) & cfg_trig_mask) == '0)) begin
      trig_hit      <= 1'b1;
      trig_cap_data <= hsel.tdata;
      trig_cap_ch   <= sel;
    end
  end
`endif

endmodule

// File: tb/tb_cr_isf_mc.sv
// Directed self-checking bench for cr_isf_mc (N_CH=2, DW=64, DEPTH=16).
module tb_cr_isf_mc;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    ib_tvalid;
  logic [1:0]    ib_tready;
  logic [127:0]  ib_tdata;
  logic [15:0]   ib_tuser;
  logic [15:0]   ib_tstrb;
  logic [1:0]    ib_tlast;
  logic          ob_tvalid;
  logic          ob_tready;
  logic [63:0]   ob_tdata;
  logic [7:0]    ob_tuser;
  logic [7:0]    ob_tstrb;
  logic          ob_tlast;
  logic [0:0]    ob_tid;
  logic [1:0]    cfg_ch_en;
  logic          cfg_single_step;
  logic          ss_rd;
  logic [15:0]   cfg_stall_limit;
  logic          stall_int;
  logic          ob_bytes_stb;
  logic [3:0]    ob_bytes_amt;
  logic [9:0]    fifo_level;
`ifdef CR_ISF_MC_TRIG_EN
  logic          cfg_trig_arm;
  logic [63:0]   cfg_trig_match;
  logic [63:0]   cfg_trig_mask;
  logic          trig_hit;
  logic [63:0]   trig_cap_data;
  logic [0:0]    trig_cap_ch;
`endif

  cr_isf_mc #(.N_CH(2), .DW(64), .UW(8), .DEPTH(16), .STALL_W(16)) dut (
    .clk(clk), .rst(rst),
    .ib_tvalid(ib_tvalid), .ib_tready(ib_tready), .ib_tdata(ib_tdata),
    .ib_tuser(ib_tuser), .ib_tstrb(ib_tstrb), .ib_tlast(ib_tlast),
    .ob_tvalid(ob_tvalid), .ob_tready(ob_tready), .ob_tdata(ob_tdata),
    .ob_tuser(ob_tuser), .ob_tstrb(ob_tstrb), .ob_tlast(ob_tlast), .ob_tid(ob_tid),
    .cfg_ch_en(cfg_ch_en), .cfg_single_step(cfg_single_step), .ss_rd(ss_rd),
    .cfg_stall_limit(cfg_stall_limit), .stall_int(stall_int),
    .ob_bytes_stb(ob_bytes_stb), .ob_bytes_amt(ob_bytes_amt),
`ifdef CR_ISF_MC_TRIG_EN
    .cfg_trig_arm(cfg_trig_arm), .cfg_trig_match(cfg_trig_match),
    .cfg_trig_mask(cfg_trig_mask), .trig_hit(trig_hit),
    .trig_cap_data(trig_cap_data), .trig_cap_ch(trig_cap_ch),
`endif
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  u;
    logic        tid;
    logic        last;
  } ob_rec_t;

  ob_rec_t     obq[$];
  int unsigned amtq[$];
  int          stall_cyc    = 0;
  int          stall_pulses = 0;
  int          pulse_at     = -1;
  int          checks       = 0;
  int          failures     = 0;

  // Egress monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (ob_tvalid && ob_tready) obq.push_back({ob_tdata, ob_tuser, ob_tid, ob_tlast});
    if (ob_bytes_stb) amtq.push_back(32'(ob_bytes_amt));
    if (stall_int) begin
      stall_pulses++;
      pulse_at = stall_cyc;
    end
    if (ob_tvalid && !ob_tready) stall_cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int ch, input logic v, input logic [63:0] d,
                     input logic [7:0] s, input logic l);
    ib_tvalid[ch]          = v;
    ib_tdata[ch*64 +: 64]  = d;
    ib_tuser[ch*8 +: 8]    = d[7:0] ^ 8'h5A;
    ib_tstrb[ch*8 +: 8]    = s;
    ib_tlast[ch]           = l;
  endtask

  function automatic logic [4:0] lvl(input int ch);
    return fifo_level[ch*5 +: 5];
  endfunction

  function automatic ob_rec_t rec(input int i);
    if (i < obq.size()) return obq[i];
    return '1;
  endfunction

  logic [63:0] t1_d   [5] = '{64'hA0, 64'hA1, 64'hA2, 64'hB0, 64'hB1};
  logic        t1_tid [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  int unsigned t1_amt [5] = '{8, 4, 1, 0, 2};
  logic [63:0] t5_d   [6] = '{64'hC0, 64'hC1, 64'hC2, 64'hC3, 64'hD0, 64'hD1};
  logic        t5_tid [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int base;
    int abase;
    int sent;
    int s0;
    int p0;
    logic acc;

    rst = 1'b1;
    ib_tvalid = '0; ib_tdata = '0; ib_tuser = '0; ib_tstrb = '0; ib_tlast = '0;
    ob_tready = 1'b0; cfg_ch_en = 2'b11; cfg_single_step = 1'b0; ss_rd = 1'b0;
    cfg_stall_limit = '0;
`ifdef CR_ISF_MC_TRIG_EN
    cfg_trig_arm = 1'b0; cfg_trig_match = '0; cfg_trig_mask = '0;
`endif
    repeat (3) tick();

    // Reset state
    chk("rst_ib_tready", 64'(ib_tready), 64'h0);
    chk("rst_ob_tvalid", 64'(ob_tvalid), 64'h0);
    chk("rst_ob_tid", 64'(ob_tid), 64'h0);
    chk("rst_stall_int", 64'(stall_int), 64'h0);
    chk("rst_bytes_stb", 64'(ob_bytes_stb), 64'h0);
    chk("rst_fifo_level", 64'(fifo_level), 64'h0);
    rst = 1'b0;
    tick();
    chk("rdy_after_rst", 64'(ib_tready), 64'h3);

    // 1: simultaneous packets, round-robin order, latency, byte counts
    ob_tready = 1'b1;
    base = obq.size();
    abase = amtq.size();
    drv(0, 1, 64'hA0, 8'hFF, 0); drv(1, 1, 64'hB0, 8'h00, 0); tick();
    chk("t1_no_valid_at_t", 64'(ob_tvalid), 64'h0);
    drv(0, 1, 64'hA1, 8'h0F, 0); drv(1, 1, 64'hB1, 8'h03, 1); tick();
    chk("t1_valid_at_t1", 64'(ob_tvalid), 64'h1);
    chk("t1_first_data", ob_tdata, 64'hA0);
    chk("t1_first_tuser", 64'(ob_tuser), 64'hFA);
    chk("t1_first_tid", 64'(ob_tid), 64'h0);
    drv(0, 1, 64'hA2, 8'h01, 1); drv(1, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0);
    repeat (10) tick();
    chk("t1_count", 64'(obq.size() - base), 64'd5);
    chk("t1_amt_count", 64'(amtq.size() - abase), 64'd5);
    for (int i = 0; i < 5; i++) begin
      chk("t1_data", rec(base + i).d, t1_d[i]);
      chk("t1_tid", 64'(rec(base + i).tid), 64'(t1_tid[i]));
      chk("t1_amt", 64'((abase + i < amtq.size()) ? amtq[abase + i] : 32'hFFFF), 64'(t1_amt[i]));
    end

    // 2: fill with egress stalled, then drain in order
    ob_tready = 1'b0;
    base = obq.size();
    sent = 0;
    for (int c = 0; c < 30; c++) begin
      drv(0, (sent < 20), 64'(sent), 8'hFF, 1);
      @(negedge clk);
      acc = ib_tready[0] && ib_tvalid[0];
      tick();
      if (acc) sent++;
    end
    drv(0, 0, 0, 0, 0);
    chk("t2_accepted", 64'(sent), 64'd17);
    chk("t2_level_full", 64'(lvl(0)), 64'd16);
    chk("t2_ready_low", 64'(ib_tready[0]), 64'h0);
    chk("t2_held_beat", ob_tdata, 64'h0);
    ob_tready = 1'b1;
    repeat (25) tick();
    chk("t2_count", 64'(obq.size() - base), 64'd17);
    for (int i = 0; i < 17; i++) chk("t2_order", rec(base + i).d, 64'(i));
    chk("t2_level_empty", 64'(lvl(0)), 64'd0);
    chk("t2_ready_back", 64'(ib_tready[0]), 64'h1);

    // 3: single-step gating and credit saturation
    cfg_single_step = 1'b1;
    base = obq.size();
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 64'h30 + 64'(i), 8'hFF, 1);
      tick();
    end
    drv(0, 0, 0, 0, 0);
    repeat (5) tick();
    chk("t3_gated_valid", 64'(ob_tvalid), 64'h0);
    chk("t3_gated_count", 64'(obq.size() - base), 64'd0);
    chk("t3_level4", 64'(lvl(0)), 64'd4);
    ss_rd = 1'b1; tick(); ss_rd = 1'b0;
    repeat (5) tick();
    chk("t3_one_beat", 64'(obq.size() - base), 64'd1);
    chk("t3_one_data", rec(base).d, 64'h30);
    ob_tready = 1'b0;
    ss_rd = 1'b1; tick(); ss_rd = 1'b0;
    repeat (3) tick();
    chk("t3_held", 64'(ob_tvalid), 64'h1);
    ss_rd = 1'b1; tick(); tick(); ss_rd = 1'b0;
    ob_tready = 1'b1;
    repeat (6) tick();
    chk("t3_sat_count", 64'(obq.size() - base), 64'd3);
    chk("t3_sat_level", 64'(lvl(0)), 64'd1);
    ss_rd = 1'b1; tick(); ss_rd = 1'b0;
    repeat (5) tick();
    chk("t3_last_count", 64'(obq.size() - base), 64'd4);
    chk("t3_last_data", rec(base + 3).d, 64'h33);
    cfg_single_step = 1'b0;

    // 4: stall watchdog
    cfg_stall_limit = 16'd5;
    s0 = stall_cyc;
    p0 = stall_pulses;
    ob_tready = 1'b0;
    drv(0, 1, 64'h40, 8'hFF, 1); tick(); drv(0, 0, 0, 0, 0);
    repeat (12) tick();
    chk("t4_one_pulse", 64'(stall_pulses - p0), 64'd1);
    chk("t4_pulse_cycle", 64'(pulse_at - s0), 64'd5);
    ob_tready = 1'b1;
    repeat (3) tick();
    cfg_stall_limit = '0;
    p0 = stall_pulses;
    ob_tready = 1'b0;
    drv(0, 1, 64'h41, 8'hFF, 1); tick(); drv(0, 0, 0, 0, 0);
    repeat (12) tick();
    chk("t4_disabled", 64'(stall_pulses - p0), 64'd0);
    ob_tready = 1'b1;
    repeat (3) tick();

    // 5: channel disable mid-packet, then reset mid-packet
    ob_tready = 1'b0;
    base = obq.size();
    drv(0, 1, 64'hC0, 8'hFF, 0); tick();
    drv(0, 1, 64'hC1, 8'hFF, 0); drv(1, 1, 64'hD0, 8'hFF, 0); tick();
    drv(0, 1, 64'hC2, 8'hFF, 0); drv(1, 1, 64'hD1, 8'hFF, 1); tick();
    drv(0, 1, 64'hC3, 8'hFF, 1); drv(1, 0, 0, 0, 0); tick();
    drv(0, 1, 64'hE0, 8'hFF, 1); tick();
    drv(0, 0, 0, 0, 0);
    cfg_ch_en = 2'b10;
    tick();
    chk("t5_ready0_off", 64'(ib_tready[0]), 64'h0);
    chk("t5_level0", 64'(lvl(0)), 64'd4);
    chk("t5_level1", 64'(lvl(1)), 64'd2);
    chk("t5_locked_head", ob_tdata, 64'hC0);
    ob_tready = 1'b1;
    repeat (12) tick();
    chk("t5_count", 64'(obq.size() - base), 64'd6);
    for (int i = 0; i < 6; i++) begin
      chk("t5_data", rec(base + i).d, t5_d[i]);
      chk("t5_tid", 64'(rec(base + i).tid), 64'(t5_tid[i]));
    end
    chk("t5_ch0_stays", 64'(lvl(0)), 64'd1);
    ob_tready = 1'b0;
    drv(1, 1, 64'hF0, 8'hFF, 0); tick();
    drv(1, 1, 64'hF1, 8'hFF, 0); tick();
    drv(1, 1, 64'hF2, 8'hFF, 0); tick();
    drv(1, 0, 0, 0, 0);
    repeat (2) tick();
    chk("t5_pre_rst_valid", 64'(ob_tvalid), 64'h1);
    base = obq.size();
    rst = 1'b1; tick();
    chk("t5_rst_levels", 64'(fifo_level), 64'h0);
    chk("t5_rst_valid", 64'(ob_tvalid), 64'h0);
    chk("t5_rst_ready", 64'(ib_tready), 64'h0);
    rst = 1'b0;
    cfg_ch_en = 2'b11;
    tick();
    chk("t5_ready_again", 64'(ib_tready), 64'h3);
    ob_tready = 1'b1;
    drv(1, 1, 64'h60, 8'hFF, 1); tick(); drv(1, 0, 0, 0, 0);
    repeat (5) tick();
    chk("t5_post_rst_count", 64'(obq.size() - base), 64'd1);
    chk("t5_post_rst_data", rec(base).d, 64'h60);
    chk("t5_post_rst_tid", 64'(rec(base).tid), 64'h1);

`ifdef CR_ISF_MC_TRIG_EN
    // 6: data-match trigger forces single-step after hit
    cfg_trig_arm = 1'b1; cfg_trig_mask = 64'hFF; cfg_trig_match = 64'hA5;
    base = obq.size();
    drv(0, 1, 64'h11, 8'hFF, 1); tick();
    drv(0, 1, 64'hA5, 8'hFF, 1); tick();
    drv(0, 1, 64'h22, 8'hFF, 1); tick();
    drv(0, 0, 0, 0, 0);
    repeat (6) tick();
    chk("t6_hit", 64'(trig_hit), 64'h1);
    chk("t6_cap_data", trig_cap_data, 64'hA5);
    chk("t6_cap_ch", 64'(trig_cap_ch), 64'h0);
    chk("t6_held_count", 64'(obq.size() - base), 64'd2);
    ss_rd = 1'b1; tick(); ss_rd = 1'b0;
    repeat (4) tick();
    chk("t6_released", rec(base + 2).d, 64'h22);
    cfg_trig_arm = 1'b0; tick();
    chk("t6_clear", 64'(trig_hit), 64'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
